// File: rtl/pre_enc_pkg.sv
// Shared definitions for the priority-encoder family.
//   MODE_FIXED / MODE_RR : values of the runtime mode input
//   enc_idx()            : maps a winner index to the output coding
//                          (plain index, or N-1-index for the legacy coding)
package pre_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Six bits covers the largest supported N (64).
  function automatic logic [5:0] enc_idx(input logic [5:0] idx,
                                         input logic       inv,
                                         input int         n);
    if (inv)
      return 6'(n - 1 - int'(idx));
    else
      return idx;
  endfunction

endpackage

// File: rtl/pri_find.sv
// Combinational lowest-set-bit finder.
//   req   in  N  request vector
//   idx   out W  index of the lowest set bit (0 when none set)
//   found out 1  at least one bit of req is set
module pri_find #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan high to low so the last assignment wins with the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pre_enc_rr.sv
// N:log2(N) priority encoder with a registered, valid/ready handshaked
// output and a runtime-selectable round-robin mode.
//   clk       in   1  rising-edge clock
//   rst_n     in   1  synchronous active-low reset
//   mode      in   1  MODE_FIXED (bit 0 highest) or MODE_RR
//   in_valid  in   1  req/mode valid this cycle
//   in_ready  out  1  block can accept a beat
//   req       in   N  request vector
//   out_valid out  1  y/gnt/none hold a result
//   out_ready in   1  consumer accepts result
//   y         out  W  encoded winner (ENC_INV selects legacy N-1-idx coding)
//   gnt       out  N  one-hot winner, zero when none=1
//   none      out  1  accepted req was all zero
module pre_enc_rr
  import pre_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int ENC_INV = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [N-1:0] gnt,
  output logic         none
);

  logic [W-1:0] ptr;
  logic [N-1:0] upper_mask;
  logic [N-1:0] req_upper;
  logic [W-1:0] up_idx, wrap_idx, win_idx;
  logic         up_found, wrap_found;
  logic         accept;
  logic [W-1:0] y_nxt;
  logic [N-1:0] gnt_nxt;

  // Single output register, no skid: a beat can enter whenever the
  // register is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Bits at or above the pointer; equivalent to ~((1<<ptr)-1).
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++)
      upper_mask[i] = (i >= int'(ptr));
  end

  assign req_upper = req & upper_mask;

  pri_find #(.N(N)) u_find_upper (
    .req   (req_upper),
    .idx   (up_idx),
    .found (up_found)
  );

  // The unmasked finder doubles as the fixed-priority result and the
  // wrap-around result for round-robin.
  pri_find #(.N(N)) u_find_wrap (
    .req   (req),
    .idx   (wrap_idx),
    .found (wrap_found)
  );

  always_comb begin
    win_idx = wrap_idx;
    if (mode == MODE_RR && up_found)
      win_idx = up_idx;
  end

  always_comb begin
    y_nxt   = '0;
    gnt_nxt = '0;
    if (wrap_found) begin
      y_nxt   = W'(enc_idx(6'(win_idx), ENC_INV != 0, N));
      gnt_nxt = N'(1) << win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      gnt       <= '0;
      none      <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= y_nxt;
      gnt       <= gnt_nxt;
      none      <= !wrap_found;
      // N is a power of two, so the W-bit increment wraps N-1 -> 0.
      if (mode == MODE_RR && wrap_found)
        ptr <= win_idx + W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pre_enc_rr.sv
module tb_pre_enc_rr;
  import pre_enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 legacy-coded instance
  logic       rst4_n, mode4, iv4, ir4, ov4, or4, none4;
  logic [3:0] req4, gnt4;
  logic [1:0] y4;

  // N=8 plain-coded instance
  logic       rst8_n, mode8, iv8, ir8, ov8, or8, none8;
  logic [7:0] req8, gnt8;
  logic [2:0] y8;

  pre_enc_rr #(.N(4), .ENC_INV(1)) dut4 (
    .clk(clk), .rst_n(rst4_n), .mode(mode4), .in_valid(iv4), .in_ready(ir4),
    .req(req4), .out_valid(ov4), .out_ready(or4), .y(y4), .gnt(gnt4), .none(none4)
  );

  pre_enc_rr #(.N(8), .ENC_INV(0)) dut8 (
    .clk(clk), .rst_n(rst8_n), .mode(mode8), .in_valid(iv8), .in_ready(ir8),
    .req(req8), .out_valid(ov8), .out_ready(or8), .y(y8), .gnt(gnt8), .none(none8)
  );

  typedef struct packed {
    logic [7:0] req;
    logic       mode;
    logic [2:0] y;
    logic [7:0] gnt;
    logic       none;
  } vec_t;

  vec_t v4[$];
  vec_t v8[$];

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // N=4, legacy coding, fixed priority
    v4.push_back('{8'h08, MODE_FIXED, 3'd0, 8'h08, 1'b0});
    v4.push_back('{8'h04, MODE_FIXED, 3'd1, 8'h04, 1'b0});
    v4.push_back('{8'h02, MODE_FIXED, 3'd2, 8'h02, 1'b0});
    v4.push_back('{8'h01, MODE_FIXED, 3'd3, 8'h01, 1'b0});
    v4.push_back('{8'h0D, MODE_FIXED, 3'd3, 8'h01, 1'b0});

    // N=8 round-robin sweep: pointer walks 0..7 and wraps
    for (int i = 0; i < 9; i++)
      v8.push_back('{8'hFF, MODE_RR, 3'(i % 8), 8'(1 << (i % 8)), 1'b0});
    // ptr=1 -> single bit 7 wins, ptr wraps to 0
    v8.push_back('{8'h80, MODE_RR, 3'd7, 8'h80, 1'b0});
    // fairness across wrap from ptr=0
    v8.push_back('{8'h81, MODE_RR, 3'd0, 8'h01, 1'b0});
    v8.push_back('{8'h81, MODE_RR, 3'd7, 8'h80, 1'b0});
    v8.push_back('{8'h81, MODE_RR, 3'd0, 8'h01, 1'b0});
    // ptr=1: bit 4 wins, ptr -> 5; empty req keeps ptr=5
    v8.push_back('{8'h10, MODE_RR, 3'd4, 8'h10, 1'b0});
    v8.push_back('{8'h00, MODE_RR, 3'd0, 8'h00, 1'b1});
    v8.push_back('{8'hFF, MODE_RR, 3'd5, 8'h20, 1'b0});
    // fixed mode ignores and preserves ptr=6
    v8.push_back('{8'hF0, MODE_FIXED, 3'd4, 8'h10, 1'b0});
    v8.push_back('{8'h06, MODE_FIXED, 3'd1, 8'h02, 1'b0});
    v8.push_back('{8'hFF, MODE_RR, 3'd6, 8'h40, 1'b0});
    v8.push_back('{8'h00, MODE_FIXED, 3'd0, 8'h00, 1'b1});

    rst4_n = 1'b0; mode4 = 1'b0; iv4 = 1'b0; or4 = 1'b1; req4 = '0;
    rst8_n = 1'b0; mode8 = 1'b0; iv8 = 1'b0; or8 = 1'b1; req8 = '0;
    tick();
    tick();
    chk("rst4_out_valid", 32'(ov4), 0);
    chk("rst8_out_valid", 32'(ov8), 0);
    chk("rst8_y", 32'(y8), 0);
    chk("rst8_gnt", 32'(gnt8), 0);
    chk("rst8_none", 32'(none8), 0);
    chk("rst8_in_ready", 32'(ir8), 1);
    rst4_n = 1'b1;
    rst8_n = 1'b1;

    // N=4 table, one beat per clock
    foreach (v4[i]) begin
      iv4 = 1'b1; mode4 = v4[i].mode; req4 = v4[i].req[3:0];
      chk($sformatf("v4[%0d]_in_ready", i), 32'(ir4), 1);
      tick();
      chk($sformatf("v4[%0d]_out_valid", i), 32'(ov4), 1);
      chk($sformatf("v4[%0d]_y", i), 32'(y4), 32'(v4[i].y[1:0]));
      chk($sformatf("v4[%0d]_gnt", i), 32'(gnt4), 32'(v4[i].gnt[3:0]));
      chk($sformatf("v4[%0d]_none", i), 32'(none4), 32'(v4[i].none));
    end
    iv4 = 1'b0;

    // N=8 table
    foreach (v8[i]) begin
      iv8 = 1'b1; mode8 = v8[i].mode; req8 = v8[i].req;
      tick();
      chk($sformatf("v8[%0d]_out_valid", i), 32'(ov8), 1);
      chk($sformatf("v8[%0d]_y", i), 32'(y8), 32'(v8[i].y));
      chk($sformatf("v8[%0d]_gnt", i), 32'(gnt8), 32'(v8[i].gnt));
      chk($sformatf("v8[%0d]_none", i), 32'(none8), 32'(v8[i].none));
    end

    // Backpressure: hold a result for 3 clocks while a new beat waits
    iv8 = 1'b1; mode8 = MODE_FIXED; req8 = 8'h01; or8 = 1'b1;
    tick();
    chk("bp_first_y", 32'(y8), 0);
    or8 = 1'b0; req8 = 8'h80;
    #1;
    chk("bp_in_ready_low", 32'(ir8), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", c), 32'(ov8), 1);
      chk($sformatf("bp_hold%0d_y", c), 32'(y8), 0);
      chk($sformatf("bp_hold%0d_gnt", c), 32'(gnt8), 32'h01);
      chk($sformatf("bp_hold%0d_none", c), 32'(none8), 0);
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(ir8), 0);
    end
    or8 = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(ir8), 1);
    tick();
    chk("bp_new_y", 32'(y8), 7);
    chk("bp_new_gnt", 32'(gnt8), 32'h80);

    // Drain, then X on req with in_valid low must not disturb outputs
    iv8 = 1'b0; req8 = 'x;
    tick();
    chk("drain_out_valid", 32'(ov8), 0);
    tick();
    chk("idle_x_out_valid", 32'(ov8), 0);
    chk("idle_x_y", 32'(y8), 7);
    chk("idle_x_gnt", 32'(gnt8), 32'h80);

    // Reset while a result is stalled; ptr is nonzero beforehand (ptr=7 -> bit 3 wins, ptr=4)
    iv8 = 1'b1; mode8 = MODE_RR; req8 = 8'h08; or8 = 1'b1;
    tick();
    chk("pre_rst_y", 32'(y8), 3);
    or8 = 1'b0; rst8_n = 1'b0; req8 = 8'hFF;
    tick();
    chk("rst_mid_out_valid", 32'(ov8), 0);
    chk("rst_mid_y", 32'(y8), 0);
    chk("rst_mid_gnt", 32'(gnt8), 0);
    rst8_n = 1'b1; or8 = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(ov8), 1);
    chk("post_rst_y", 32'(y8), 0);
    chk("post_rst_gnt", 32'(gnt8), 32'h01);
    iv8 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
